jtlabrun_gfx_bus: RTL and testbench

//  CPU-bus responder for the video block: answers the main CPU's gfx_cs/gfx_addr accesses.

---
 rtl/jtlabrun_gfx_bus.sv | 147 ++++++++++++++
 tb/tb_jtlabrun_gfx_bus.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtlabrun_gfx_bus.sv
// CPU-bus responder for the video block.
// Holds 8 control registers and a dual-port VRAM. It feeds scroll and flip to
// the tilemap engine, and it raises the frame IRQ and the periodic NMI.
// Build option: define JTLABRUN_REGRD_EN to make the control registers readable.
// When the macro is undefined, register reads return 8'hff, as on the PCB.
module jtlabrun_gfx_bus #(
    parameter int VRAM_AW   = 13,
    parameter int IRQ_LINE  = 240,
    parameter int NMI_LINES = 32,
    parameter int NMI_LEN   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_cen,
    input  logic               gfx_cs,
    input  logic [13:0]        gfx_addr,
    input  logic               cpu_rnw,
    input  logic [7:0]         cpu_dout,
    output logic [7:0]         gfx_dout,
    output logic               gfx_irqn,
    output logic               gfx_nmin,
    input  logic [8:0]         vdump,
    input  logic [8:0]         hdump,
    input  logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_data,
    output logic [8:0]         scrx,
    output logic [7:0]         scry,
    output logic               flip
);

    localparam int         NMI_SH    = $clog2(NMI_LINES);
    localparam logic [4:0] NMI_LOAD  = 5'(NMI_LEN);
    localparam logic [8:0] IRQ_VLINE = 9'(IRQ_LINE);

`ifdef JTLABRUN_REGRD_EN
    localparam bit REGRD = 1'b1;
`else
    localparam bit REGRD = 1'b0;
`endif

    typedef enum logic {
        IRQ_IDLE   = 1'b0,
        IRQ_ACTIVE = 1'b1
    } irq_state_t;

    logic [7:0]  regs_q [0:7];
    logic [7:0]  vram   [0:(1<<VRAM_AW)-1];
    logic [7:0]  gfx_dout_q;
    logic [7:0]  vram_data_q;
    logic        h0_q;
    irq_state_t  irq_state_q, irq_state_d;
    logic [4:0]  nmi_cnt_q, nmi_cnt_d;

    logic        we, reg_we, vram_we;
    logic        line_start, irq_trig, irq_ack, nmi_trig;
    logic [7:0]  reg_rd;

    // One write per CPU bus cycle: the enable qualifies the select.
    assign we      = gfx_cs & ~cpu_rnw & cpu_cen;
    assign vram_we = we &  gfx_addr[13];
    assign reg_we  = we & ~gfx_addr[13];

    // hdump stays at zero for several clocks, so only its first clock starts a line.
    assign line_start = (hdump == 9'd0) & ~h0_q;
    assign irq_trig   = line_start & (vdump == IRQ_VLINE) & regs_q[3][1];
    assign irq_ack    = reg_we & (gfx_addr[2:0] == 3'd3) & ~cpu_dout[1];
    assign nmi_trig   = line_start & (vdump[NMI_SH-1:0] == '0) & regs_q[3][0];

    assign reg_rd = REGRD ? regs_q[gfx_addr[2:0]] : 8'hff;

    assign scrx      = {regs_q[1][0], regs_q[0]};
    assign scry      = regs_q[2];
    assign flip      = regs_q[3][3];
    assign gfx_dout  = gfx_dout_q;
    assign vram_data = vram_data_q;

    // Control register file, written from the CPU bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else if (reg_we) begin
            regs_q[gfx_addr[2:0]] <= cpu_dout;
        end
    end

    // VRAM write port (CPU side).
    // NOTE: the memory array has no reset. Its contents must survive a reset
    // in mid-frame, and a reset port would stop the array mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (vram_we) vram[gfx_addr[VRAM_AW-1:0]] <= cpu_dout;
    end

    // Video-side read port with one clock of latency.
    // NOTE: the read uses a nonblocking assignment in the same edge as the
    // write, so a write to the same address returns the old data (read-before-write).
    always_ff @(posedge clk) begin
        if (rst) vram_data_q <= '0;
        else     vram_data_q <= vram[vram_addr];
    end

    // CPU read data, registered. A VRAM access takes priority when bit 13 is set.
    always_ff @(posedge clk) begin
        if (rst)                    gfx_dout_q <= '0;
        else if (gfx_cs & cpu_rnw)  gfx_dout_q <= gfx_addr[13] ? vram[gfx_addr[VRAM_AW-1:0]] : reg_rd;
    end

    // Delayed copy of (hdump == 0) for the line-start edge detector. It resets
    // high, so leaving reset inside hdump == 0 does not start a line.
    always_ff @(posedge clk) begin
        if (rst) h0_q <= 1'b1;
        else     h0_q <= (hdump == 9'd0);
    end

    // State registers for the IRQ FSM and the NMI pulse counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_state_q <= IRQ_IDLE;
            nmi_cnt_q   <= '0;
        end else begin
            irq_state_q <= irq_state_d;
            nmi_cnt_q   <= nmi_cnt_d;
        end
    end

    // Next state and outputs for the IRQ and NMI.
    // NOTE: every signal gets its default first, so no path can infer a latch.
    always_comb begin
        irq_state_d = irq_state_q;
        nmi_cnt_d   = nmi_cnt_q;
        gfx_irqn    = 1'b1;
        gfx_nmin    = 1'b1;

        case (irq_state_q)
            IRQ_IDLE:   if (irq_trig) irq_state_d = IRQ_ACTIVE;
            IRQ_ACTIVE: if ((vdump == 9'd0) || irq_ack) irq_state_d = IRQ_IDLE;
            default:    irq_state_d = IRQ_IDLE;
        endcase

        // A running pulse ignores retriggers, and it also ignores nmi_en being cleared.
        if (nmi_cnt_q != 5'd0)  nmi_cnt_d = nmi_cnt_q - 5'd1;
        else if (nmi_trig)      nmi_cnt_d = NMI_LOAD;

        if (irq_state_q == IRQ_ACTIVE) gfx_irqn = 1'b0;
        if (nmi_cnt_q != 5'd0)         gfx_nmin = 1'b0;
    end

endmodule

// File: tb/tb_jtlabrun_gfx_bus.sv
// Self-checking bench for jtlabrun_gfx_bus.
// Directed checks cover the VRAM, the registers, the IRQ, the NMI and reset.
// A random bus phase is then compared against a memory/register model.
module tb_jtlabrun_gfx_bus;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_cen;
    logic        gfx_cs;
    logic [13:0] gfx_addr;
    logic        cpu_rnw;
    logic [7:0]  cpu_dout;
    logic [7:0]  gfx_dout;
    logic        gfx_irqn;
    logic        gfx_nmin;
    logic [8:0]  vdump;
    logic [8:0]  hdump;
    logic [12:0] vram_addr;
    logic [7:0]  vram_data;
    logic [8:0]  scrx;
    logic [7:0]  scry;
    logic        flip;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: VRAM image, register file and the expected CPU read data.
    logic [7:0] mem_m [0:8191];
    logic [7:0] reg_m [0:7];
    logic [7:0] exp_dout;

    jtlabrun_gfx_bus dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_cen   (cpu_cen),
        .gfx_cs    (gfx_cs),
        .gfx_addr  (gfx_addr),
        .cpu_rnw   (cpu_rnw),
        .cpu_dout  (cpu_dout),
        .gfx_dout  (gfx_dout),
        .gfx_irqn  (gfx_irqn),
        .gfx_nmin  (gfx_nmin),
        .vdump     (vdump),
        .hdump     (hdump),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .scrx      (scrx),
        .scry      (scry),
        .flip      (flip)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] reg_read_m(input logic [2:0] a);
`ifdef JTLABRUN_REGRD_EN
        return reg_m[a];
`else
        return 8'hff;
`endif
    endfunction

    task automatic bus_write(input logic [13:0] a, input logic [7:0] d);
        gfx_cs = 1'b1; cpu_rnw = 1'b0; gfx_addr = a; cpu_dout = d; cpu_cen = 1'b1;
        tick();
        gfx_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0;
        if (a[13]) mem_m[a[12:0]] = d;
        else       reg_m[a[2:0]]  = d;
    endtask

    task automatic bus_read(input string tag, input logic [13:0] a);
        gfx_cs = 1'b1; cpu_rnw = 1'b1; gfx_addr = a; cpu_cen = 1'b0;
        exp_dout = a[13] ? mem_m[a[12:0]] : reg_read_m(a[2:0]);
        tick();
        gfx_cs = 1'b0;
        check(tag, gfx_dout, exp_dout);
    endtask

    // Runs one NMI trigger at line v. Optionally it forces a retrigger, or it
    // clears nmi_en in the middle of the pulse. It returns the number of clocks gfx_nmin was low.
    task automatic nmi_pulse(input logic [8:0] v, input bit retrig, input bit clr_en, output int low);
        low = 0;
        vdump = v; hdump = 9'd0;
        for (int i = 0; i < 40; i++) begin
            if (i == 3) hdump = 9'd5;
            if (retrig && i == 5) begin vdump = v + 9'd32; hdump = 9'd0; end
            if (retrig && i == 7) hdump = 9'd5;
            if (clr_en && i == 6) begin
                gfx_cs = 1'b1; cpu_rnw = 1'b0; gfx_addr = 14'h0003; cpu_dout = 8'h00; cpu_cen = 1'b1;
                reg_m[3] = 8'h00;
            end
            if (clr_en && i == 7) begin gfx_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0; end
            tick();
            if (gfx_nmin === 1'b0) low++;
        end
        hdump = 9'd5;
    endtask

    initial begin
        int low;
        logic        r_cs, r_rnw, r_cen;
        logic [13:0] r_addr;
        logic [7:0]  r_data, exp_vd;

        rst = 1'b1; cpu_cen = 1'b0; gfx_cs = 1'b0; gfx_addr = '0; cpu_rnw = 1'b1;
        cpu_dout = '0; vdump = 9'd1; hdump = 9'd5; vram_addr = '0;
        for (int i = 0; i < 8; i++) reg_m[i] = 8'h00;
        exp_dout = 8'h00;

        // Reset state, sampled while reset is held.
        repeat (3) tick();
        check("rst_dout",  gfx_dout,  8'h00);
        check("rst_vdata", vram_data, 8'h00);
        check("rst_scrx",  scrx,      9'h000);
        check("rst_scry",  scry,      8'h00);
        check("rst_flip",  flip,      1'b0);
        check("rst_irqn",  gfx_irqn,  1'b1);
        check("rst_nmin",  gfx_nmin,  1'b1);
        rst = 1'b0;
        tick();

        // VRAM write then CPU read and video-port read.
        bus_write(14'h2123, 8'h5A);
        bus_read("vram_cpu_rd", 14'h2123);
        vram_addr = 13'h0123;
        tick();
        check("vram_video_rd", vram_data, 8'h5A);

        // Read-before-write on the video port.
        gfx_cs = 1'b1; cpu_rnw = 1'b0; gfx_addr = 14'h2123; cpu_dout = 8'hA5; cpu_cen = 1'b1;
        tick();
        gfx_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0;
        mem_m[13'h0123] = 8'hA5;
        check("rbw_old", vram_data, 8'h5A);
        tick();
        check("rbw_new", vram_data, 8'hA5);

        // Scroll and flip registers.
        bus_write(14'h0000, 8'h34);
        bus_write(14'h0001, 8'h01);
        bus_write(14'h0002, 8'h80);
        check("scrx", scrx, 9'h134);
        check("scry", scry, 8'h80);
        check("flip0", flip, 1'b0);
        bus_write(14'h0003, 8'h08);
        check("flip1", flip, 1'b1);
`ifdef JTLABRUN_REGRD_EN
        bus_read("reg2_rd", 14'h0002);
        check("reg2_rd_val", exp_dout, 8'h80);
`else
        bus_read("reg2_rd", 14'h0002);
        check("reg2_rd_val", exp_dout, 8'hff);
`endif

        // Frame IRQ: trigger, hold, then acknowledge by writing reg3.
        bus_write(14'h0003, 8'h02);
        vdump = 9'd240; hdump = 9'd5; tick();
        hdump = 9'd0; tick();
        check("irq_set", gfx_irqn, 1'b0);
        repeat (3) tick();
        check("irq_hold", gfx_irqn, 1'b0);
        bus_write(14'h0003, 8'h00);
        check("irq_ack", gfx_irqn, 1'b1);
        hdump = 9'd5; tick();

        // Frame IRQ cleared when vdump reaches line 0.
        bus_write(14'h0003, 8'h02);
        hdump = 9'd0; tick();
        check("irq_set2", gfx_irqn, 1'b0);
        hdump = 9'd5; vdump = 9'd0; tick();
        check("irq_vclr", gfx_irqn, 1'b1);

        // No IRQ when irq_en is clear.
        bus_write(14'h0003, 8'h00);
        vdump = 9'd240; tick();
        hdump = 9'd0; tick(); tick();
        check("irq_dis", gfx_irqn, 1'b1);
        hdump = 9'd5; tick();

        // NMI pulse width, non-matching line, retrigger, and enable cleared mid-pulse.
        bus_write(14'h0003, 8'h01);
        nmi_pulse(9'd32, 1'b0, 1'b0, low);
        check("nmi_len", low, 16);
        nmi_pulse(9'd33, 1'b0, 1'b0, low);
        check("nmi_off_line", low, 0);
        nmi_pulse(9'd32, 1'b1, 1'b0, low);
        check("nmi_retrig", low, 16);
        nmi_pulse(9'd64, 1'b0, 1'b1, low);
        check("nmi_en_clr", low, 16);
        nmi_pulse(9'd96, 1'b0, 1'b0, low);
        check("nmi_disabled", low, 0);

        // Reset while the NMI pulse runs and the IRQ is active.
        bus_write(14'h0003, 8'h03);
        vdump = 9'd240; hdump = 9'd0; tick();
        check("pre_rst_irq", gfx_irqn, 1'b0);
        hdump = 9'd5; vdump = 9'd256; tick();
        hdump = 9'd0; tick();
        check("pre_rst_nmi", gfx_nmin, 1'b0);
        check("pre_rst_irq2", gfx_irqn, 1'b0);
        hdump = 9'd5; tick();
        rst = 1'b1; tick();
        check("mid_rst_nmin", gfx_nmin, 1'b1);
        check("mid_rst_irqn", gfx_irqn, 1'b1);
        check("mid_rst_scrx", scrx, 9'h000);
        check("mid_rst_dout", gfx_dout, 8'h00);
        check("mid_rst_vdata", vram_data, 8'h00);
        rst = 1'b0; vdump = 9'd1;
        for (int i = 0; i < 8; i++) reg_m[i] = 8'h00;
        tick();
        bus_read("vram_kept", 14'h2123);

        // Prefill a VRAM window, then run a random bus phase against the model.
        for (int i = 0; i < 64; i++) bus_write(14'h2100 + 14'(i), 8'($urandom));
        for (int c = 0; c < 3000; c++) begin
            r_cs   = ($urandom_range(0, 9) < 7);
            r_rnw  = 1'($urandom);
            r_cen  = ($urandom_range(0, 2) == 0);
            r_addr = 1'($urandom) ? (14'h2100 + 14'($urandom_range(0, 63)))
                                  : 14'($urandom_range(0, 7));
            r_data = 8'($urandom);
            gfx_cs = r_cs; cpu_rnw = r_rnw; cpu_cen = r_cen; gfx_addr = r_addr; cpu_dout = r_data;
            vram_addr = 13'h0100 + 13'($urandom_range(0, 63));

            if (r_cs && r_rnw)
                exp_dout = r_addr[13] ? mem_m[r_addr[12:0]] : reg_read_m(r_addr[2:0]);
            exp_vd = mem_m[vram_addr];
            if (r_cs && !r_rnw && r_cen) begin
                if (r_addr[13]) mem_m[r_addr[12:0]] = r_data;
                else            reg_m[r_addr[2:0]]  = r_data;
            end

            tick();
            check("rnd_dout",  gfx_dout,  exp_dout);
            check("rnd_vdata", vram_data, exp_vd);
            check("rnd_scrx",  scrx,      {reg_m[1][0], reg_m[0]});
            check("rnd_scry",  scry,      reg_m[2]);
            check("rnd_flip",  flip,      reg_m[3][3]);
            check("rnd_irqn",  gfx_irqn,  1'b1);
            check("rnd_nmin",  gfx_nmin,  1'b1);
        end
        gfx_cs = 1'b0; cpu_cen = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
